// File: rtl/loac_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package loac_pkg;

  // Default operand/result width.
  localparam int L = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

  // Carry-out of a full adder: set when at least two inputs are set.
  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder used as the per-cycle slice of the serial subtractor.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  import loac_pkg::*;

  // Sum and carry for a single bit position.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = majority(a, b, cin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor: S = A - B computed LSB first as A + ~B + 1,
// one bit per clock, with Z/N/P/V status flags registered on completion.
module serial_subtractor #(
  parameter int L = loac_pkg::L
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic [L-1:0] A,
  input  logic [L-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [L-1:0] S,
  output logic         Z,
  output logic         N,
  output logic         P,
  output logic         V
);
  import loac_pkg::*;

  localparam int CNT_W = $clog2(L);

  sub_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [L-1:0]       a_sh_q, a_sh_d;
  logic [L-1:0]       b_sh_q, b_sh_d;
  logic [L-1:0]       r_sh_q, r_sh_d;
  logic               carry_q, carry_d;
  logic               a_sign_q, a_sign_d;
  logic               b_sign_q, b_sign_d;
  logic [L-1:0]       s_q, s_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic               p_q, p_d;
  logic               v_q, v_d;

  logic               fa_s;
  logic               fa_cout;
  logic [L-1:0]       s_res;

  full_adder_bit u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  // Next-state, shift datapath and result capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    r_sh_d   = r_sh_q;
    carry_d  = carry_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    s_d      = s_q;
    z_d      = z_q;
    n_d      = n_q;
    p_d      = p_q;
    v_d      = v_q;
    // Result word including the bit being produced this cycle.
    s_res    = {fa_s, r_sh_q[L-1:1]};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = A;
          b_sh_d   = ~B;
          carry_d  = 1'b1;         // the +1 of the two's complement negation
          cnt_d    = '0;
          a_sign_d = A[L-1];
          b_sign_d = B[L-1];       // kept apart: the shifters lose the sign bits
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d  = {1'b0, a_sh_q[L-1:1]};
        b_sh_d  = {1'b0, b_sh_q[L-1:1]};
        r_sh_d  = s_res;
        carry_d = fa_cout;         // final carry (inverted borrow) is dropped
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(L - 1)) begin
          state_d = DONE;
          s_d     = s_res;
          z_d     = (s_res == '0);
          n_d     = s_res[L-1];
          p_d     = ~s_res[0];
          v_d     = (a_sign_q != b_sign_q) && (s_res[L-1] != a_sign_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      s_q      <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      p_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      r_sh_q   <= r_sh_d;
      carry_q  <= carry_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      s_q      <= s_d;
      z_q      <= z_d;
      n_q      <= n_d;
      p_q      <= p_d;
      v_q      <= v_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Z    = z_q;
  assign N    = n_q;
  assign P    = p_q;
  assign V    = v_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: cycle-level behavioural model plus directed
// literal cases and a randomized traffic phase.
module tb_serial_subtractor;
  localparam int L = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [L-1:0] A = '0;
  logic [L-1:0] B = '0;
  logic         busy, done, Z, N, P, V;
  logic [L-1:0] S;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  serial_subtractor #(.L(L)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .S       (S),
    .Z       (Z),
    .N       (N),
    .P       (P),
    .V       (V)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // since = cycles elapsed since the accepting edge (-1 when idle).
  int           since = -1;
  logic [L-1:0] pend_s, e_s = '0;
  logic         pend_v, e_z = 0, e_n = 0, e_p = 0, e_v = 0;

  always @(posedge clock) begin
    if (!reset_n) begin
      since = -1;
      e_s = '0; e_z = 0; e_n = 0; e_p = 0; e_v = 0;
    end else if (since < 0) begin
      if (start) begin
        int d;
        d = int'($signed(A)) - int'($signed(B));
        pend_s = d[L-1:0];
        pend_v = (d > (2**(L-1)) - 1) || (d < -(2**(L-1)));
        since = 1;
      end
    end else if (since == L + 1) begin
      since = -1;
    end else begin
      since = since + 1;
      if (since == L + 1) begin
        e_s = pend_s;
        e_z = (pend_s == 0);
        e_n = pend_s[L-1];
        e_p = ~pend_s[0];
        e_v = pend_v;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy", busy, (since >= 1));
      check("cyc_done", done, (since == L + 1));
      check("cyc_S", S, e_s);
      check("cyc_flags", {Z, N, P, V}, {e_z, e_n, e_p, e_v});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_op(input string name, input logic [L-1:0] a, input logic [L-1:0] b,
                        input logic [L-1:0] es, input logic ez, input logic en,
                        input logic ep, input logic ev);
    int n;
    @(negedge clock);
    A = a; B = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; A = $urandom; B = $urandom;
    n = 1;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({name, "_latency"}, n, L + 1);
    check({name, "_S"}, S, es);
    check({name, "_ZNPV"}, {Z, N, P, V}, {ez, en, ep, ev});
  endtask

  initial begin
    int n, dcount;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_S", S, 0);
    check("rst_flags", {Z, N, P, V}, 0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    run_op("5m3",     8'd5,   8'd3,   8'h02, 0, 0, 1, 0);
    run_op("5m5",     8'd5,   8'd5,   8'h00, 1, 0, 1, 0);
    run_op("3m5",     8'd3,   8'd5,   8'hFE, 0, 1, 1, 0);
    run_op("m128m1",  8'h80,  8'h01,  8'h7F, 0, 0, 0, 1);
    run_op("127mm1",  8'h7F,  8'hFF,  8'h80, 0, 1, 1, 1);
    run_op("0m128",   8'h00,  8'h80,  8'h80, 0, 1, 1, 1);

    // Start while busy is ignored.
    @(negedge clock);
    A = 8'd10; B = 8'd4; start = 1'b1;      // cycle 0
    @(negedge clock); start = 1'b0;         // cycle 1
    repeat (3) @(negedge clock);            // cycle 4
    A = 8'd1; B = 8'd1; start = 1'b1;
    @(negedge clock); start = 1'b0;         // cycle 5
    n = 5; dcount = 0;
    while (n < 9) begin @(negedge clock); n++; dcount += int'(done); end
    check("busy_ign_done_c9", done, 1);
    check("busy_ign_S", S, 8'h06);
    A = 8'd9; B = 8'd2; start = 1'b1;       // cycle 9: ignored (DONE)
    @(negedge clock);                       // cycle 10
    check("busy_ign_idle_c10", busy, 0);
    A = 8'd20; B = 8'd30; start = 1'b1;     // accepted at end of cycle 10
    @(negedge clock); start = 1'b0;
    check("restart_busy", busy, 1);
    repeat (L) @(negedge clock);
    check("restart_S", S, 8'hF6);
    check("single_done_count", dcount, 1);

    // Reset mid-run.
    @(negedge clock);
    A = 8'd7; B = 8'd2; start = 1'b1;       // cycle 0
    @(negedge clock); start = 1'b0;         // cycle 1
    repeat (4) @(negedge clock);            // cycle 5
    reset_n = 1'b0;
    @(negedge clock);                       // cycle 6
    check("abort_busy", busy, 0);
    check("abort_S", S, 0);
    check("abort_flags", {Z, N, P, V, done}, 0);
    reset_n = 1'b1;
    dcount = 0;
    repeat (12) begin @(negedge clock); dcount += int'(done); end
    check("abort_no_done", dcount, 0);
    run_op("post_rst", 8'd7, 8'd2, 8'h05, 0, 0, 0, 0);

    // Randomized traffic, occasional reset, boundary operands mixed in.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      start   = ($urandom_range(0, 2) == 0);
      reset_n = ($urandom_range(0, 149) != 0);
      case ($urandom_range(0, 5))
        0: A = 8'h80;
        1: A = 8'h7F;
        default: A = L'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: B = 8'h80;
        1: B = A;
        default: B = L'($urandom);
      endcase
    end
    @(negedge clock);
    start = 1'b0; reset_n = 1'b1;
    repeat (L + 3) @(negedge clock);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
